// File: rtl/xdma_pkg.sv
// Shared definitions for the xdma block: register map, control/status bit
// positions, FSM state encoding and default widths.
package xdma_pkg;

   localparam int ADDR_W = 12;
   localparam int DATA_W = 32;

   localparam logic [1:0] XDMA_ADDR   = 2'd0;
   localparam logic [1:0] XDMA_LEN    = 2'd1;
   localparam logic [1:0] XDMA_CTRL   = 2'd2;
   localparam logic [1:0] XDMA_STATUS = 2'd3;

   localparam int CTRL_START = 0;
   localparam int CTRL_DIR   = 1;
   localparam int CTRL_ABORT = 2;

   localparam int STAT_BUSY = 0;
   localparam int STAT_DONE = 1;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RD_REQ  = 3'd1,
      S_RD_WAIT = 3'd2,
      S_RD_OUT  = 3'd3,
      S_WR_WAIT = 3'd4,
      S_WR      = 3'd5
   } state_t;

endpackage

// File: rtl/xdma_regs.sv
// Controller-facing register file for xdma: ADDR/LEN configuration, the
// start/abort strobes decoded from CTRL writes, and the registered read port.
module xdma_regs
   import xdma_pkg::*;
#(
   parameter int MEM_AW = ADDR_W - 1,
   parameter int DW     = DATA_W,
   parameter int LEN_W  = ADDR_W - 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_sel,
   input  logic              i_we,
   input  logic [1:0]        i_addr,
   input  logic [DW-1:0]     i_data,
   input  logic              i_busy,
   input  logic              i_done,
   output logic [DW-1:0]     o_data,
   output logic [MEM_AW-1:0] o_addr,
   output logic [LEN_W-1:0]  o_len,
   output logic              o_start,
   output logic              o_dir,
   output logic              o_abort
);

   logic [MEM_AW-1:0] r_addr;
   logic [LEN_W-1:0]  r_len;
   logic [DW-1:0]     r_data;
   logic [DW-1:0]     w_rd_mux;
   logic              w_wr;
   logic              w_rd;
   logic              w_ctrl_wr;
   logic              w_unused;

   assign w_wr      = i_sel & i_we;
   assign w_rd      = i_sel & ~i_we;
   assign w_ctrl_wr = w_wr && (i_addr == XDMA_CTRL);

   // Start is only honoured when idle, abort only when busy.
   assign o_start = w_ctrl_wr & i_data[CTRL_START] & ~i_busy;
   assign o_abort = w_ctrl_wr & i_data[CTRL_ABORT] & i_busy;
   assign o_dir   = i_data[CTRL_DIR];

   assign w_unused = &{1'b0, i_data};

   // NOTE: every signal driven in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      w_rd_mux = '0;
      case (i_addr)
         XDMA_ADDR:   w_rd_mux[MEM_AW-1:0] = r_addr;
         XDMA_LEN:    w_rd_mux[LEN_W-1:0]  = r_len;
         XDMA_STATUS: begin
            w_rd_mux[STAT_BUSY] = i_busy;
            w_rd_mux[STAT_DONE] = i_done;
         end
         default:     w_rd_mux = '0;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values regardless of block order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_addr <= '0;
         r_len  <= '0;
         r_data <= '0;
      end else begin
         if (w_wr && !i_busy) begin
            if (i_addr == XDMA_ADDR) r_addr <= i_data[MEM_AW-1:0];
            if (i_addr == XDMA_LEN)  r_len  <= i_data[LEN_W-1:0];
         end
         if (w_rd) r_data <= w_rd_mux;
      end
   end

   assign o_data = r_data;
   assign o_addr = r_addr;
   assign o_len  = r_len;

endmodule

// File: rtl/xdma.sv
// DMA engine moving word blocks between the shared RAM data port and a
// ready/valid stream; the controller always has priority on the RAM port.
module xdma
   import xdma_pkg::*;
#(
   parameter int MEM_AW = ADDR_W - 1,
   parameter int DW     = DATA_W,
   parameter int LEN_W  = ADDR_W - 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sel,
   input  logic              we,
   input  logic [1:0]        addr,
   input  logic [DW-1:0]     data_in,
   output logic [DW-1:0]     data_out,
   input  logic              ctrl_data_sel,
   output logic              dma_sel,
   output logic              dma_we,
   output logic [MEM_AW-1:0] dma_addr,
   output logic [DW-1:0]     dma_data_in,
   input  logic [DW-1:0]     dma_data_out,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DW-1:0]     m_data,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DW-1:0]     s_data
);

   state_t            r_state;
   state_t            w_next;
   logic [MEM_AW-1:0] r_waddr;
   logic [LEN_W-1:0]  r_wcnt;
   logic              r_done;
   logic [DW-1:0]     r_m_data;
   logic [DW-1:0]     r_wdata;

   logic [MEM_AW-1:0] w_cfg_addr;
   logic [LEN_W-1:0]  w_cfg_len;
   logic              w_start;
   logic              w_dir;
   logic              w_abort;
   logic              w_busy;
   logic              w_last;
   logic              w_m_hs;
   logic              w_s_hs;
   logic              w_wr_grant;
   logic              w_step;

   xdma_regs #(
      .MEM_AW (MEM_AW),
      .DW     (DW),
      .LEN_W  (LEN_W)
   ) u_regs (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_sel   (sel),
      .i_we    (we),
      .i_addr  (addr),
      .i_data  (data_in),
      .i_busy  (w_busy),
      .i_done  (r_done),
      .o_data  (data_out),
      .o_addr  (w_cfg_addr),
      .o_len   (w_cfg_len),
      .o_start (w_start),
      .o_dir   (w_dir),
      .o_abort (w_abort)
   );

   assign w_busy     = (r_state != S_IDLE);
   assign w_last     = (r_wcnt <= LEN_W'(1));
   assign w_m_hs     = (r_state == S_RD_OUT) && m_ready;
   assign w_s_hs     = (r_state == S_WR_WAIT) && s_valid;
   assign w_wr_grant = (r_state == S_WR) && !ctrl_data_sel;
   assign w_step     = w_m_hs | w_wr_grant;

   // NOTE: reset is synchronous, so it is only tested inside the clocked block.
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      if (w_start) begin
         if (w_cfg_len == '0) w_next = S_IDLE;
         else if (w_dir)      w_next = S_WR_WAIT;
         else                 w_next = S_RD_REQ;
      end else if (w_abort) begin
         w_next = S_IDLE;
      end else begin
         case (r_state)
            S_RD_REQ:  if (!ctrl_data_sel) w_next = S_RD_WAIT;
            S_RD_WAIT: w_next = S_RD_OUT;
            S_RD_OUT:  if (m_ready) w_next = w_last ? S_IDLE : S_RD_REQ;
            S_WR_WAIT: if (s_valid) w_next = S_WR;
            S_WR:      if (!ctrl_data_sel) w_next = w_last ? S_IDLE : S_WR_WAIT;
            default:   w_next = S_IDLE;
         endcase
      end
   end

   always_comb begin
      dma_sel = (r_state == S_RD_REQ) || (r_state == S_WR);
      dma_we  = (r_state == S_WR);
      m_valid = (r_state == S_RD_OUT);
      s_ready = (r_state == S_WR_WAIT);
   end

   // An abort drops the in-flight word: nothing advances in that cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_waddr  <= '0;
         r_wcnt   <= '0;
         r_done   <= 1'b0;
         r_m_data <= '0;
         r_wdata  <= '0;
      end else if (w_start) begin
         r_waddr <= w_cfg_addr;
         r_wcnt  <= w_cfg_len;
         r_done  <= (w_cfg_len == '0);
      end else if (!w_abort) begin
         if (w_step) begin
            r_waddr <= r_waddr + MEM_AW'(1);
            if (r_wcnt != '0) r_wcnt <= r_wcnt - LEN_W'(1);
            if (w_last)       r_done <= 1'b1;
         end
         if (r_state == S_RD_WAIT) r_m_data <= dma_data_out;
         if (w_s_hs)               r_wdata  <= s_data;
      end
   end

   assign dma_addr    = r_waddr;
   assign dma_data_in = r_wdata;
   assign m_data      = r_m_data;

endmodule

// File: tb/tb_xdma.sv
// Directed scoreboard bench for xdma: a behavioural RAM with 1-cycle read
// latency, stream driver/monitor and expected-value queues.
module tb_xdma;
   import xdma_pkg::*;

   localparam int MEM_AW = 11;
   localparam int DW     = 32;
   localparam int LEN_W  = 11;

   logic              clk;
   logic              rst_n;
   logic              sel;
   logic              we;
   logic [1:0]        addr;
   logic [DW-1:0]     data_in;
   logic [DW-1:0]     data_out;
   logic              ctrl_data_sel;
   logic              dma_sel;
   logic              dma_we;
   logic [MEM_AW-1:0] dma_addr;
   logic [DW-1:0]     dma_data_in;
   logic [DW-1:0]     dma_data_out;
   logic              m_valid;
   logic              m_ready;
   logic [DW-1:0]     m_data;
   logic              s_valid;
   logic              s_ready;
   logic [DW-1:0]     s_data;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int rd_grants = 0;
   int sel_cyc = 0;
   int m_hs = 0;
   int s_hs = 0;

   logic [DW-1:0]        m_exp_q[$];
   logic [MEM_AW+DW-1:0] w_exp_q[$];
   int                   wr_cyc_q[$];
   logic [DW-1:0]        ram   [2**MEM_AW];
   bit                   ram_w [2**MEM_AW];
   logic [DW-1:0]        wv    [4];

   xdma #(
      .MEM_AW (MEM_AW),
      .DW     (DW),
      .LEN_W  (LEN_W)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .sel           (sel),
      .we            (we),
      .addr          (addr),
      .data_in       (data_in),
      .data_out      (data_out),
      .ctrl_data_sel (ctrl_data_sel),
      .dma_sel       (dma_sel),
      .dma_we        (dma_we),
      .dma_addr      (dma_addr),
      .dma_data_in   (dma_data_in),
      .dma_data_out  (dma_data_out),
      .m_valid       (m_valid),
      .m_ready       (m_ready),
      .m_data        (m_data),
      .s_valid       (s_valid),
      .s_ready       (s_ready),
      .s_data        (s_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [DW-1:0] init_val(input int a);
      return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
   endfunction

   // RAM model: granted read data appears one cycle later.
   always @(posedge clk) begin
      if (dma_sel && !ctrl_data_sel) begin
         if (dma_we) begin
            ram[dma_addr]   <= dma_data_in;
            ram_w[dma_addr] <= 1'b1;
         end else begin
            dma_data_out <= ram_w[dma_addr] ? ram[dma_addr] : init_val(int'(dma_addr));
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Monitor samples mid-cycle what the DUT will see at the next edge.
   initial forever begin
      logic [MEM_AW+DW-1:0] w_exp;
      @(negedge clk);
      if (dma_sel === 1'b1) sel_cyc++;
      if (dma_sel === 1'b1 && !ctrl_data_sel) begin
         if (dma_we === 1'b0) begin
            rd_grants++;
         end else begin
            wr_cyc_q.push_back(cyc);
            if (w_exp_q.size() == 0) begin
               check("wr_unexpected", 64'd1, 64'd0);
            end else begin
               w_exp = w_exp_q.pop_front();
               check("wr_addr", 64'(dma_addr), 64'(w_exp[MEM_AW+DW-1:DW]));
               check("wr_data", 64'(dma_data_in), 64'(w_exp[DW-1:0]));
            end
         end
      end
      if (m_valid === 1'b1 && m_ready) begin
         m_hs++;
         if (m_exp_q.size() == 0) check("m_unexpected", 64'd1, 64'd0);
         else                     check("m_data", 64'(m_data), 64'(m_exp_q.pop_front()));
      end
      if (s_valid && s_ready === 1'b1) s_hs++;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reg_write(input logic [1:0] a, input logic [DW-1:0] d);
      tick();
      sel = 1'b1; we = 1'b1; addr = a; data_in = d;
      tick();
      sel = 1'b0; we = 1'b0;
   endtask

   task automatic reg_read(input logic [1:0] a, output logic [DW-1:0] d);
      tick();
      sel = 1'b1; we = 1'b0; addr = a;
      tick();
      sel = 1'b0;
      d = data_out;
   endtask

   task automatic wait_idle(input string tag);
      logic [DW-1:0] st;
      st = 32'h1;
      for (int i = 0; i < 200 && st[STAT_BUSY]; i++) reg_read(XDMA_STATUS, st);
      check({tag, "_idle"}, 64'(st[STAT_BUSY]), 64'd0);
   endtask

   task automatic feed(input int n, input int base, input string tag);
      int k;
      int t;
      k = s_hs - base;
      t = 0;
      while (k < n && t < 100) begin
         tick();
         t++;
         k = s_hs - base;
         if (k < n) s_data = wv[k];
      end
      s_valid = 1'b0;
      check({tag, "_feed"}, 64'(k), 64'(n));
   endtask

   initial begin
      logic [DW-1:0] rd;
      int base_rd;
      int base_m;
      int base_s;
      int base_sel;
      int sc;
      int t;

      rst_n = 1'b0; sel = 1'b0; we = 1'b0; addr = '0; data_in = '0;
      ctrl_data_sel = 1'b0; m_ready = 1'b0; s_valid = 1'b0; s_data = '0;
      repeat (3) tick();

      check("rst_ctl", 64'({dma_sel, dma_we, m_valid, s_ready, dma_addr}), 64'd0);
      check("rst_data_out", 64'(data_out), 64'd0);
      check("rst_dma_data_in", 64'(dma_data_in), 64'd0);
      check("rst_m_data", 64'(m_data), 64'd0);
      rst_n = 1'b1;
      reg_read(XDMA_ADDR, rd);   check("rst_reg_addr", 64'(rd), 64'd0);
      reg_read(XDMA_LEN, rd);    check("rst_reg_len", 64'(rd), 64'd0);
      reg_read(XDMA_STATUS, rd); check("rst_status", 64'(rd), 64'd0);

      // MEM2EXT, 4 words from 0x010
      m_ready = 1'b1;
      for (int i = 0; i < 4; i++) m_exp_q.push_back(init_val(16 + i));
      base_rd = rd_grants; base_m = m_hs;
      reg_write(XDMA_ADDR, 32'h010);
      reg_write(XDMA_LEN, 32'd4);
      reg_write(XDMA_CTRL, 32'h1);
      check("m2e_sel_n1", 64'(dma_sel), 64'd1);
      check("m2e_mvalid_n1", 64'(m_valid), 64'd0);
      tick();
      check("m2e_mvalid_n2", 64'(m_valid), 64'd0);
      tick();
      check("m2e_mvalid_n3", 64'(m_valid), 64'd1);
      check("m2e_mdata_n3", 64'(m_data), 64'(init_val(16)));
      wait_idle("m2e");
      reg_read(XDMA_STATUS, rd); check("m2e_status", 64'(rd), 64'd2);
      check("m2e_reads", 64'(rd_grants - base_rd), 64'd4);
      check("m2e_words", 64'(m_hs - base_m), 64'd4);
      check("m2e_q_empty", 64'(m_exp_q.size()), 64'd0);

      // EXT2MEM wrapping past the top of RAM
      wv[0] = 32'hA5A5_0001; wv[1] = 32'hB6B6_0002; wv[2] = 32'hC7C7_0003;
      w_exp_q.push_back({11'h7FE, wv[0]});
      w_exp_q.push_back({11'h7FF, wv[1]});
      w_exp_q.push_back({11'h000, wv[2]});
      wr_cyc_q.delete();
      s_valid = 1'b1; s_data = wv[0];
      reg_write(XDMA_ADDR, 32'h7FE);
      reg_write(XDMA_LEN, 32'd3);
      base_s = s_hs;
      reg_write(XDMA_CTRL, 32'h3);
      sc = cyc;
      check("e2m_sready_n1", 64'({s_ready, dma_sel}), 64'b10);
      feed(3, base_s, "e2m");
      wait_idle("e2m");
      check("e2m_nwr", 64'(wr_cyc_q.size()), 64'd3);
      if (wr_cyc_q.size() == 3) begin
         check("e2m_first_wr_cyc", 64'(wr_cyc_q[0] - sc), 64'd1);
         check("e2m_last_wr_cyc", 64'(wr_cyc_q[2] - sc), 64'd5);
      end
      check("e2m_ram_7fe", 64'(ram[11'h7FE]), 64'(wv[0]));
      check("e2m_ram_7ff", 64'(ram[11'h7FF]), 64'(wv[1]));
      check("e2m_ram_000", 64'(ram[11'h000]), 64'(wv[2]));
      reg_read(XDMA_STATUS, rd); check("e2m_status", 64'(rd), 64'd2);

      // Controller contention for 5 cycles during the first WR
      wv[0] = 32'h1111_D000; wv[1] = 32'h2222_D001;
      w_exp_q.push_back({11'h100, wv[0]});
      w_exp_q.push_back({11'h101, wv[1]});
      wr_cyc_q.delete();
      s_valid = 1'b1; s_data = wv[0];
      reg_write(XDMA_ADDR, 32'h100);
      reg_write(XDMA_LEN, 32'd2);
      base_s = s_hs;
      reg_write(XDMA_CTRL, 32'h3);
      sc = cyc;
      tick();
      check("cont_in_wr", 64'({dma_sel, dma_we}), 64'b11);
      s_data = wv[1];
      ctrl_data_sel = 1'b1;
      repeat (5) tick();
      ctrl_data_sel = 1'b0;
      check("cont_no_wr_stall", 64'(wr_cyc_q.size()), 64'd0);
      feed(2, base_s, "cont");
      wait_idle("cont");
      check("cont_nwr", 64'(wr_cyc_q.size()), 64'd2);
      if (wr_cyc_q.size() == 2) begin
         check("cont_first_wr_cyc", 64'(wr_cyc_q[0] - sc), 64'd6);
         check("cont_last_wr_cyc", 64'(wr_cyc_q[1] - sc), 64'd8);
      end
      check("cont_ram_100", 64'(ram[11'h100]), 64'(wv[0]));
      check("cont_ram_101", 64'(ram[11'h101]), 64'(wv[1]));

      // Backpressure: m_ready low for 10 cycles after the first word
      m_ready = 1'b1;
      for (int i = 0; i < 4; i++) m_exp_q.push_back(init_val(32'h20 + i));
      base_rd = rd_grants; base_m = m_hs;
      reg_write(XDMA_ADDR, 32'h020);
      reg_write(XDMA_LEN, 32'd4);
      reg_write(XDMA_CTRL, 32'h1);
      t = 0;
      while (m_hs - base_m < 1 && t < 50) begin tick(); t++; end
      m_ready = 1'b0;
      check("bp_first_word", 64'(m_hs - base_m), 64'd1);
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (i >= 2) check("bp_hold", {31'd0, m_valid, m_data}, {31'd0, 1'b1, init_val(32'h21)});
      end
      check("bp_reads_held", 64'(rd_grants - base_rd), 64'd2);
      check("bp_words_held", 64'(m_hs - base_m), 64'd1);
      m_ready = 1'b1;
      wait_idle("bp");
      check("bp_words", 64'(m_hs - base_m), 64'd4);
      check("bp_reads", 64'(rd_grants - base_rd), 64'd4);
      check("bp_q_empty", 64'(m_exp_q.size()), 64'd0);

      // LEN=0 start
      base_sel = sel_cyc; base_m = m_hs;
      reg_write(XDMA_LEN, 32'd0);
      reg_write(XDMA_CTRL, 32'h1);
      reg_read(XDMA_STATUS, rd); check("len0_status", 64'(rd), 64'd2);
      repeat (3) tick();
      check("len0_no_sel", 64'(sel_cyc - base_sel), 64'd0);
      check("len0_no_words", 64'(m_hs - base_m), 64'd0);

      // Abort after 2 of 8 words
      m_ready = 1'b1;
      for (int i = 0; i < 8; i++) m_exp_q.push_back(init_val(32'h40 + i));
      base_m = m_hs;
      reg_write(XDMA_ADDR, 32'h040);
      reg_write(XDMA_LEN, 32'd8);
      reg_write(XDMA_CTRL, 32'h1);
      t = 0;
      while (m_hs - base_m < 2 && t < 50) begin tick(); t++; end
      reg_write(XDMA_CTRL, 32'h4);
      check("abort_outs", 64'({dma_sel, m_valid, s_ready}), 64'd0);
      repeat (4) tick();
      check("abort_words", 64'(m_hs - base_m), 64'd2);
      reg_read(XDMA_STATUS, rd); check("abort_status", 64'(rd), 64'd0);
      check("abort_q_left", 64'(m_exp_q.size()), 64'd6);
      m_exp_q.delete();

      // Reset during a second transfer, stalled in RD_OUT
      m_ready = 1'b0;
      reg_write(XDMA_ADDR, 32'h200);
      reg_write(XDMA_LEN, 32'd4);
      reg_write(XDMA_CTRL, 32'h1);
      repeat (2) tick();
      check("rst_mid_mvalid", 64'(m_valid), 64'd1);
      reg_read(XDMA_ADDR, rd); check("rst_mid_addr_rd", 64'(rd), 64'h200);
      base_sel = sel_cyc;
      rst_n = 1'b0;
      tick();
      check("rst_mid_ctl", 64'({dma_sel, dma_we, m_valid, s_ready, dma_addr}), 64'd0);
      check("rst_mid_data_out", 64'(data_out), 64'd0);
      check("rst_mid_dma_data_in", 64'(dma_data_in), 64'd0);
      check("rst_mid_m_data", 64'(m_data), 64'd0);
      tick();
      rst_n = 1'b1;
      check("rst_mid_no_access", 64'(sel_cyc - base_sel), 64'd0);
      reg_read(XDMA_ADDR, rd);   check("rst_mid_reg_addr", 64'(rd), 64'd0);
      reg_read(XDMA_LEN, rd);    check("rst_mid_reg_len", 64'(rd), 64'd0);
      reg_read(XDMA_STATUS, rd); check("rst_mid_status", 64'(rd), 64'd0);

      check("end_m_q", 64'(m_exp_q.size()), 64'd0);
      check("end_w_q", 64'(w_exp_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/xdma.md
# xdma

DMA engine that acts as the initiator on the shared data port of the program/data RAM, moving word blocks between that RAM and an external ready/valid stream. The picoVersat controller configures it through a 4-register peripheral interface. The controller always wins the shared port: the engine's access goes through only in cycles where the controller leaves the port free.

## Interface
- MEM_AW, default `ADDR_W-1: RAM word-address width.
- DW, default `DATA_W: data word width.
- LEN_W, default `ADDR_W-1: transfer-length counter width.

- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- sel  in  1  controller register access strobe
- we  in  1  controller write enable, qualified by sel
- addr  in  2  register index
- data_in  in  DW  controller write data
- data_out  out  DW  register read data, valid 1 cycle after sel
- ctrl_data_sel  in  1  controller is using the RAM data port this cycle (DMA access lost)
- dma_sel  out  1  RAM data-port enable request
- dma_we  out  1  RAM write enable
- dma_addr  out  MEM_AW  RAM word address
- dma_data_in  out  DW  RAM write data
- dma_data_out  in  DW  RAM read data, valid 1 cycle after a granted read
- m_valid / m_ready / m_data  out / in / out DW  outbound stream (RAM to external)
- s_valid / s_ready / s_data  in / out / in DW  inbound stream (external to RAM)

## Operation
- Registers:
  - 0 ADDR (MEM_AW bits): start address.
  - 1 LEN (LEN_W bits): word count.
  - 2 CTRL: write-only strobes; bit0 start, bit1 dir (0 = MEM2EXT, 1 = EXT2MEM), bit2 abort.
  - 3 STATUS: bit0 busy, bit1 done.
- Reads of CTRL return 0.
- Writes to ADDR and LEN while busy are ignored. Start while busy is ignored. Abort while idle has no effect.
- Start latches ADDR into the working address and LEN into the working count, clears done, and enters RD_REQ (dir 0) or WR_WAIT (dir 1).
- Start with LEN=0: sets done, stays IDLE, no RAM or stream activity.
- States: IDLE, RD_REQ, RD_WAIT, RD_OUT, WR_WAIT, WR.
  - RD_REQ: dma_sel=1, dma_we=0. If ctrl_data_sel=1, the access is lost and the engine stays in RD_REQ. Otherwise go to RD_WAIT.
  - RD_WAIT: capture dma_data_out into m_data, go to RD_OUT.
  - RD_OUT: m_valid=1, m_data held stable. On m_ready: address +1, count −1. Go to RD_REQ if count ≠ 0 after decrement; otherwise go to IDLE and set done.
  - WR_WAIT: s_ready=1. On s_valid, capture s_data, go to WR.
  - WR: dma_sel=1, dma_we=1, dma_data_in = captured word. If ctrl_data_sel=1, stay in WR. Otherwise address +1, count −1, then go to WR_WAIT, or to IDLE with done set when the count reaches 0.
- The working address wraps from 2^MEM_AW−1 to 0. The count is never decremented below 0.
- Abort in any non-IDLE state: go to IDLE next cycle, done stays 0, the in-flight word is discarded, and m_valid/s_ready drop.
- done is sticky. It is cleared only by start or reset.
- busy = (state ≠ IDLE).

## Timing
- Reset values:
  - Outputs: data_out, dma_sel, dma_we, dma_addr, dma_data_in, m_valid, m_data and s_ready are all 0.
  - Registers: ADDR=0, LEN=0, done=0, state IDLE.
- Reset mid-transfer aborts with no further RAM access in the cycle after reset is sampled.
- The register read is registered: data_out is updated on the cycle after sel && !we and holds otherwise.
- The start write is sampled at edge N. dma_sel is asserted in cycle N+1.
  - MEM2EXT, no contention: m_valid in cycle N+3. Minimum 3 cycles per word.
  - EXT2MEM, s_valid held high: first RAM write at cycle N+2. Minimum 2 cycles per word.
- Each cycle with ctrl_data_sel=1 during RD_REQ or WR adds exactly one cycle of latency.
- m_valid is never deasserted without m_ready. m_data is stable while m_valid=1 and m_ready=0.
- Register access and a DMA transfer can happen in the same cycle. A STATUS read returns busy/done as of the preceding edge.

## Structure
- xdefs.vh holds:
  - register indices (XDMA_ADDR=0, XDMA_LEN=1, XDMA_CTRL=2, XDMA_STATUS=3);
  - CTRL/STATUS bit positions;
  - 3-bit state encodings.
- One natural sub-module: xdma_regs, which holds the register file, the start/abort strobes and the data_out register. The FSM, datapath and counters stay in xdma.

## Test plan
- MEM2EXT: ADDR=0x010, LEN=4, m_ready=1 → m_data = RAM[0x010..0x013] in order. done=1 and busy=0 afterwards. Exactly 4 granted reads.
- EXT2MEM: ADDR=0x7FE with MEM_AW=11, LEN=3, words A,B,C → RAM[0x7FE]=A, RAM[0x7FF]=B, RAM[0x000]=C (wrap).
- Contention: ctrl_data_sel=1 for 5 cycles while in WR → the write is issued only after ctrl_data_sel drops. RAM data is correct and the transfer takes 5 extra cycles.
- Backpressure: m_ready=0 for 10 cycles mid-block → m_valid and m_data held constant, no extra RAM reads, no words lost.
- LEN=0 start → done=1 on the next STATUS read, dma_sel never asserted.
- Abort after 2 of 8 words, then rst_n=0 during a second transfer → IDLE, done=0, all outputs return to their reset values.
